// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a
// start/busy/done handshake. Define BIN2BCD_BLANK_EN for leading-zero blanking.
module bin2bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SCR_W = BCD_W + 4 + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   adjusted;
    logic               lost;
    logic               load;
    logic               step;
    logic               finish;
    logic               res_ovf;
    logic [BCD_W-1:0]   res_bcd;
`ifdef BIN2BCD_BLANK_EN
    logic               leading;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                busy       = 1'b1;
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble and the guard nibble before the shift.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i <= DIGITS; i++) begin
            if (scratch[BIN_W + 4*i +: 4] >= 4'd5) begin
                adjusted[BIN_W + 4*i +: 4] = scratch[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // 'lost' remembers any bit shifted out past the guard nibble, so values far
    // beyond the display range can never wrap the guard back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch <= '0;
            cnt     <= '0;
            lost    <= 1'b0;
        end else if (load) begin
            scratch <= {{(BCD_W + 4){1'b0}}, bin_in};
            cnt     <= CNT_W'(BIN_W);
            lost    <= 1'b0;
        end else if (step) begin
            scratch <= {adjusted[SCR_W-2:0], 1'b0};
            cnt     <= cnt - CNT_W'(1);
            lost    <= lost | adjusted[SCR_W-1];
        end
    end

    always_comb begin
        res_ovf = lost || (scratch[SCR_W-1 -: 4] != 4'd0);
        res_bcd = scratch[BIN_W +: BCD_W];
`ifdef BIN2BCD_BLANK_EN
        leading = 1'b1;
`endif
        if (res_ovf) begin
            res_bcd = {DIGITS{4'd9}};
        end
`ifdef BIN2BCD_BLANK_EN
        else begin
            // Digit 0 is never blanked so a zero value still shows "0".
            for (int d = DIGITS - 1; d >= 1; d--) begin
                if (leading && (res_bcd[4*d +: 4] == 4'd0)) begin
                    res_bcd[4*d +: 4] = 4'hF;
                end else begin
                    leading = 1'b0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                bcd_out <= res_bcd;
                ovf     <= res_ovf;
            end
        end
    end

endmodule
